td4x_cpu_core: RTL and testbench
================================

// Module: td4x_cpu_core
// PURPOSE
//  Parametrised next-generation TD4-class accumulator CPU: A/B registers, output port, carry and zero flags, PC.
//  Fetches one instruction per cycle from an external program ROM/switch bus, with a valid handshake for stalls.
//  Adds conditional jumps on carry and zero, HALT/resume, and an output write strobe.
//  Sits between the Tiny Tapeout pin wrapper (ui_in/uio_in/uo_out) and the program source.
// PARAMETERS
//  DATA_W  4  width of A, B, out, in_port and the immediate field; must be >= ADDR_W
//  ADDR_W  4  PC width; jump target = imm[ADDR_W-1:0]
// PORTS
//  clk          in   1          rising-edge clock, single domain
//  rst_n        in   1          synchronous active-low reset
//  instr        in   4+DATA_W   {op[3:0], imm[DATA_W-1:0]} at address pc
//  instr_valid  in   1          instr is valid this cycle; low = stall
//  in_port      in   DATA_W     external input for the IN instructions
//  resume       in   1          one-cycle pulse leaves HALT
//  pc           out  ADDR_W     fetch address (registered)
//  out_port     out  DATA_W     output port register
//  out_we       out  1          1-cycle pulse in the cycle after an OUT retires
//  halted       out  1          high while in HALT
//  carry        out  1          carry flag
//  zero         out  1          zero flag
// BEHAVIOUR
//  Reset: while rst_n is low at a clk edge, pc=0, A=B=out_port=0, carry=zero=0, out_we=0, halted=0, state=RUN.
//   Reset overrides instr_valid and resume in the same cycle, and aborts any instruction in progress.
//  One instruction retires per clk edge when state=RUN and instr_valid=1. All results are registered (latency 1).
//  ALU: {c,r} = src + imm, computed at DATA_W+1 bits. src is one of A, B, in_port or 0, selected by the opcode.
//  Opcodes:
//   0000 ADD A,im   0001 MOV A,B    0010 IN A       0011 MOV A,im
//   0100 MOV B,A    0101 ADD B,im   0110 IN B       0111 MOV B,im
//   1001 OUT B      1011 OUT im     1110 JNC im     1111 JMP im
//   1100 JC im      1101 JZ im      1010 HALT       1000 NOP
//  MOV A,B, MOV B,A, IN A and IN B add their imm field like the other ALU ops; programs use imm=0 for a plain move.
//  OUT B writes B+im; OUT im writes 0+im.
//  Flags: every retired instruction except NOP and HALT writes carry=c and zero=(r==0). Jumps compute 0+im.
//  Jump conditions use the flag values from before the instruction. JNC is taken if carry=0; JC if carry=1;
//   JZ if zero=1; JMP always. Taken: pc<=imm[ADDR_W-1:0]. Otherwise pc<=pc+1, wrapping 2^ADDR_W-1 -> 0.
//  Stall: instr_valid=0 in RUN holds pc, A, B, out_port and the flags; out_we=0.
//  FSM, 2 states:
//   RUN  -> HALT on a retired HALT. pc stays at the HALT address; halted=1 from the next cycle.
//   HALT -> RUN on resume=1. pc<=pc+1; instr and instr_valid are ignored in that cycle.
//   In HALT all registers hold and out_we=0. resume in RUN is ignored.
//  out_we=1 exactly one cycle after each retired OUT, aligned with the new out_port value.
//   Back-to-back OUTs keep out_we high.
// CONFIGURATION
//  TD4X_SUB_EN defined: opcode 1000 = SUB A,im. {c,r} = A + ~im + 1, so carry=1 means no borrow;
//   writes A and both flags.
//  TD4X_SUB_EN undefined: opcode 1000 = NOP. pc<=pc+1 and nothing else changes.
// TESTING (DATA_W=4, ADDR_W=4)
//  1. Reset, MOV A,3; ADD A,14 -> A=1, carry=1, zero=0; then JC 5 -> pc=5.
//  2. ADD A,0 with A=0, then JZ 9 -> zero=1, pc=9. JNC 2 with carry=1 -> pc advances by 1.
//  3. Drop instr_valid for 3 cycles mid-program -> pc, A, B and flags unchanged; execution resumes on the same
//     instruction. pc=15 with NOP -> pc=0.
//  4. OUT im with im=10 -> out_port=10 and a single-cycle out_we pulse.
//     Two consecutive OUT B with B=6 -> out_we high 2 cycles.
//  5. HALT at pc=4 -> halted=1, pc stays 4 for 10 cycles. resume pulse -> pc=5, halted=0.
//     rst_n low during HALT -> all outputs reset next edge.
//  6. TD4X_SUB_EN: A=2, SUB A,3 -> A=15, carry=0. Without the macro: A=2 holds, pc+1.

Source files
------------

// File: rtl/td4x_cpu_core.sv
// TD4-class accumulator CPU core: A/B registers, output port, carry/zero flags, PC with RUN/HALT control.
// Optional feature macro TD4X_SUB_EN turns opcode 1000 from NOP into SUB A,im.
module td4x_cpu_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+3:0] instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] in_port,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] out_port,
  output logic              out_we,
  output logic              halted,
  output logic              carry,
  output logic              zero
);

  // Handshake: an instruction is consumed only on a rising edge where the core
  // is in RUN and instr_valid is high; instr must be stable for that edge.
  // With instr_valid low the core holds everything and fetches the same pc again.

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_A,
    SRC_B,
    SRC_IN
  } src_t;

  typedef enum logic [1:0] {
    DST_NONE,
    DST_A,
    DST_B,
    DST_OUT
  } dst_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_NOP    = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_HALT   = 4'b1010;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JC     = 4'b1100;
  localparam logic [3:0] OP_JZ     = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state, state_next;
  logic [DATA_W-1:0] a_reg, b_reg;

  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  src_t              src_sel;
  dst_t              dst_sel;
  logic              flags_en;
  logic              is_jump;
  logic              jump_cond;
  logic              is_halt;
  logic              sub_op;

  logic [DATA_W-1:0] src_val;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum;

  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] a_next, b_next, out_next;
  logic              we_next, carry_next, zero_next;

  assign op  = instr[DATA_W+3:DATA_W];
  assign imm = instr[DATA_W-1:0];

  // Instruction decode: source operand, destination, flag write and control flow.
  always_comb begin
    src_sel   = SRC_ZERO;
    dst_sel   = DST_NONE;
    flags_en  = 1'b1;
    is_jump   = 1'b0;
    jump_cond = 1'b0;
    is_halt   = 1'b0;
    sub_op    = 1'b0;
    case (op)
      OP_ADD_A:  begin src_sel = SRC_A;    dst_sel = DST_A;   end
      OP_MOV_AB: begin src_sel = SRC_B;    dst_sel = DST_A;   end
      OP_IN_A:   begin src_sel = SRC_IN;   dst_sel = DST_A;   end
      OP_MOV_AI: begin src_sel = SRC_ZERO; dst_sel = DST_A;   end
      OP_MOV_BA: begin src_sel = SRC_A;    dst_sel = DST_B;   end
      OP_ADD_B:  begin src_sel = SRC_B;    dst_sel = DST_B;   end
      OP_IN_B:   begin src_sel = SRC_IN;   dst_sel = DST_B;   end
      OP_MOV_BI: begin src_sel = SRC_ZERO; dst_sel = DST_B;   end
      OP_OUT_B:  begin src_sel = SRC_B;    dst_sel = DST_OUT; end
      OP_OUT_I:  begin src_sel = SRC_ZERO; dst_sel = DST_OUT; end
      OP_JC:     begin is_jump = 1'b1; jump_cond = carry;  end
      OP_JZ:     begin is_jump = 1'b1; jump_cond = zero;   end
      OP_JNC:    begin is_jump = 1'b1; jump_cond = ~carry; end
      OP_JMP:    begin is_jump = 1'b1; jump_cond = 1'b1;   end
      OP_HALT:   begin is_halt = 1'b1; flags_en = 1'b0;    end
      OP_NOP: begin
`ifdef TD4X_SUB_EN
        src_sel = SRC_A;
        dst_sel = DST_A;
        sub_op  = 1'b1;
`else
        flags_en = 1'b0;
`endif
      end
      default: flags_en = 1'b0;
    endcase
  end

  always_comb begin
    src_val = '0;
    case (src_sel)
      SRC_A:   src_val = a_reg;
      SRC_B:   src_val = b_reg;
      SRC_IN:  src_val = in_port;
      default: src_val = '0;
    endcase
  end

  // Subtract is A + ~imm + 1, so carry out reads as "no borrow".
  assign operand = sub_op ? ~imm : imm;
  assign sum     = {1'b0, src_val} + {1'b0, operand} + {{DATA_W{1'b0}}, sub_op};

  always_comb begin
    state_next = state;
    pc_next    = pc;
    a_next     = a_reg;
    b_next     = b_reg;
    out_next   = out_port;
    we_next    = 1'b0;
    carry_next = carry;
    zero_next  = zero;
    case (state)
      RUN: begin
        if (instr_valid) begin
          pc_next = pc + PC_ONE;
          if (is_halt) begin
            state_next = HALT;
            pc_next    = pc;
          end
          if (is_jump && jump_cond) begin
            pc_next = imm[ADDR_W-1:0];
          end
          if (flags_en) begin
            carry_next = sum[DATA_W];
            zero_next  = (sum[DATA_W-1:0] == '0);
          end
          case (dst_sel)
            DST_A: a_next = sum[DATA_W-1:0];
            DST_B: b_next = sum[DATA_W-1:0];
            DST_OUT: begin
              out_next = sum[DATA_W-1:0];
              we_next  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      HALT: begin
        // The fetch bus is ignored on the resume cycle; execution restarts after the HALT.
        if (resume) begin
          state_next = RUN;
          pc_next    = pc + PC_ONE;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      out_port <= '0;
      out_we   <= 1'b0;
      carry    <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      a_reg    <= a_next;
      b_reg    <= b_next;
      out_port <= out_next;
      out_we   <= we_next;
      carry    <= carry_next;
      zero     <= zero_next;
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_td4x_cpu_core.sv
// Self-checking bench for td4x_cpu_core (DATA_W=4, ADDR_W=4): vector table plus HALT/reset sequences,
// with a queue of expected out_port values consumed on every out_we pulse.
module tb_td4x_cpu_core;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic [3:0] in_port;
  logic       resume;
  logic [3:0] pc;
  logic [3:0] out_port;
  logic       out_we;
  logic       halted;
  logic       carry;
  logic       zero;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

`ifdef TD4X_SUB_EN
  localparam logic [3:0] SUB_OUT = 4'd15;
  localparam logic       SUB_C   = 1'b0;
`else
  localparam logic [3:0] SUB_OUT = 4'd2;
  localparam logic       SUB_C   = 1'b1;
`endif

  typedef struct packed {
    logic       rst_n;
    logic       valid;
    logic [7:0] instr;
    logic [3:0] in_port;
    logic       resume;
    logic [3:0] pc;
    logic [3:0] out;
    logic       we;
    logic       halted;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vq[$];

  td4x_cpu_core #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .instr_valid(instr_valid),
    .in_port    (in_port),
    .resume     (resume),
    .pc         (pc),
    .out_port   (out_port),
    .out_we     (out_we),
    .halted     (halted),
    .carry      (carry),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] ins,
                              input logic [3:0] inp, input logic res, input logic [3:0] p,
                              input logic [3:0] o, input logic w, input logic h,
                              input logic c, input logic z);
    mk = '{r, v, ins, inp, res, p, o, w, h, c, z};
  endfunction

  task automatic step(input vec_t v, input string name);
    logic [11:0] got;
    logic [11:0] want;
    @(negedge clk);
    rst_n       = v.rst_n;
    instr_valid = v.valid;
    instr       = v.instr;
    in_port     = v.in_port;
    resume      = v.resume;
    if (v.we) exp_q.push_back(v.out);
    @(posedge clk);
    #1;
    got  = {pc, out_port, out_we, halted, carry, zero};
    want = {v.pc, v.out, v.we, v.halted, v.c, v.z};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got pc=%0d out=%0d we=%b halted=%b c=%b z=%b, want pc=%0d out=%0d we=%b halted=%b c=%b z=%b",
               name, got[11:8], got[7:4], got[3], got[2], got[1], got[0],
               want[11:8], want[7:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  // Scoreboard: each out_we pulse must match the oldest expected OUT value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_we_unexpected: got out_port=%0d, want no pulse", out_port);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (out_port !== e) begin
          errors++;
          $display("FAIL out_scoreboard: got out_port=%0d, want %0d", out_port, e);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 8'h00;
    in_port     = 4'h0;
    resume      = 1'b0;

    //            rst v  instr in res  pc  out     we h  c      z
    vq.push_back(mk(0, 0, 8'h00, 0, 0,  0,  0,      0, 0, 0,     0)); // reset
    vq.push_back(mk(0, 1, 8'h3F, 0, 1,  0,  0,      0, 0, 0,     0)); // reset beats valid/resume
    vq.push_back(mk(1, 1, 8'h33, 0, 0,  1,  0,      0, 0, 0,     0)); // MOV A,3
    vq.push_back(mk(1, 1, 8'h0E, 0, 0,  2,  0,      0, 0, 1,     0)); // ADD A,14 -> A=1 c=1
    vq.push_back(mk(1, 1, 8'hC5, 0, 0,  5,  0,      0, 0, 0,     0)); // JC 5 taken
    vq.push_back(mk(1, 1, 8'h40, 0, 0,  6,  0,      0, 0, 0,     0)); // MOV B,A
    vq.push_back(mk(1, 1, 8'h90, 0, 0,  7,  1,      1, 0, 0,     0)); // OUT B -> 1
    vq.push_back(mk(1, 1, 8'h30, 0, 0,  8,  1,      0, 0, 0,     1)); // MOV A,0
    vq.push_back(mk(1, 1, 8'h00, 0, 0,  9,  1,      0, 0, 0,     1)); // ADD A,0 -> z=1
    vq.push_back(mk(1, 1, 8'hD9, 0, 0,  9,  1,      0, 0, 0,     0)); // JZ 9 taken
    vq.push_back(mk(1, 1, 8'hD3, 0, 0, 10,  1,      0, 0, 0,     0)); // JZ 3 not taken
    vq.push_back(mk(1, 1, 8'h3F, 0, 0, 11,  1,      0, 0, 0,     0)); // MOV A,15
    vq.push_back(mk(1, 1, 8'h01, 0, 0, 12,  1,      0, 0, 1,     1)); // ADD A,1 -> 0 c=1 z=1
    vq.push_back(mk(1, 1, 8'hE2, 0, 0, 13,  1,      0, 0, 0,     0)); // JNC 2 with c=1: pc+1
    vq.push_back(mk(1, 1, 8'hE2, 0, 0,  2,  1,      0, 0, 0,     0)); // JNC 2 with c=0: taken
    vq.push_back(mk(1, 1, 8'hFE, 0, 0, 14,  1,      0, 0, 0,     0)); // JMP 14
    vq.push_back(mk(1, 1, 8'h5F, 0, 0, 15,  1,      0, 0, 1,     1)); // ADD B,15 -> B=0 c=1 z=1
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(1, 0, 8'h0F, 9, 1, 15,  1,      0, 0, 1,     1)); // stall holds
    vq.push_back(mk(1, 1, 8'h80, 0, 0,  0,  1,      0, 0, 1,     1)); // NOP/SUB 0 at pc 15 wraps
    vq.push_back(mk(1, 1, 8'h90, 0, 0,  1,  0,      1, 0, 0,     1)); // OUT B -> 0
    vq.push_back(mk(1, 1, 8'hBA, 0, 0,  2, 10,      1, 0, 0,     0)); // OUT 10 back-to-back
    vq.push_back(mk(1, 1, 8'h61, 5, 1,  3, 10,      0, 0, 0,     0)); // IN B +1 -> 6, resume ignored
    vq.push_back(mk(1, 1, 8'h90, 0, 0,  4,  6,      1, 0, 0,     0)); // OUT B
    vq.push_back(mk(1, 1, 8'h90, 0, 0,  5,  6,      1, 0, 0,     0)); // OUT B again
    vq.push_back(mk(1, 1, 8'h20, 3, 0,  6,  6,      0, 0, 0,     0)); // IN A -> 3
    vq.push_back(mk(1, 1, 8'h0F, 0, 0,  7,  6,      0, 0, 1,     0)); // ADD A,15 -> 2 c=1
    vq.push_back(mk(1, 1, 8'h83, 0, 0,  8,  6,      0, 0, SUB_C, 0)); // SUB A,3 or NOP
    vq.push_back(mk(1, 1, 8'h40, 0, 0,  9,  6,      0, 0, 0,     0)); // MOV B,A
    vq.push_back(mk(1, 1, 8'h90, 0, 0, 10, SUB_OUT, 1, 0, 0,     0)); // OUT B shows A
    vq.push_back(mk(1, 1, 8'hF4, 0, 0,  4, SUB_OUT, 0, 0, 0,     0)); // JMP 4
    vq.push_back(mk(1, 1, 8'hA0, 0, 0,  4, SUB_OUT, 0, 1, 0,     0)); // HALT at 4

    for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i));

    // HALT holds for 10 cycles even with a valid OUT on the bus.
    for (int i = 0; i < 10; i++)
      step(mk(1, 1, 8'hBF, 0, 0, 4, SUB_OUT, 0, 1, 0, 0), $sformatf("halt_hold%0d", i));
    step(mk(1, 1, 8'hBF, 0, 1, 5, SUB_OUT, 0, 0, 0, 0), "resume");
    step(mk(1, 1, 8'hA0, 0, 0, 5, SUB_OUT, 0, 1, 0, 0), "halt_again");
    step(mk(0, 1, 8'hBF, 0, 1, 0, 0,       0, 0, 0, 0), "reset_in_halt");
    step(mk(1, 1, 8'hB3, 0, 0, 1, 3,       1, 0, 0, 0), "run_after_reset");
    step(mk(1, 0, 8'h00, 0, 0, 1, 3,       0, 0, 0, 0), "idle");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL out_queue_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
